led_blink_decoder: RTL and testbench
====================================

// Module: led_blink_decoder
// PURPOSE
//  Receive side of the LED status blink code: samples an LED/photodiode or loopback pin and recovers the
//  2-bit status word. Line code: 16-slot frame, CNTR_TICK clocks/slot. Slots 0-9 low; pulses may occur
//  in slots 10/12/14; slots 11/13/15 low. One pulse = state 0, two = 1, three = 2. For bench loopback and
//  for a board that monitors a neighbour's status LED.
// PARAMETERS
//  CNTR_TICK   4    clocks per slot (must equal transmitter tick)
//  TOL         1    +/- clock tolerance on pulse width and inter-pulse gap
//  GAP_SLOTS   8    low-run length (slots) that closes a frame
//  LOSS_SLOTS  40   slots with no rising edge before link is declared lost
//  RUN_W       8    run-length counter width; must hold LOSS_SLOTS*CNTR_TICK
// PORTS
//  Clk          in   1  system clock, single domain
//  Rst_n        in   1  asynchronous active-low reset
//  led_in       in   1  raw asynchronous blink input
//  state        out  2  last decoded status (0..2)
//  state_valid  out  1  high while state is from a good, current frame
//  frame_done   out  1  1-cycle strobe: good frame decoded, state updated this cycle
//  frame_err    out  1  1-cycle strobe: malformed frame discarded
//  err_cnt      out  8  saturating count of frame_err strobes
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=HUNT, counters 0. Reset mid-frame discards the frame.
//  - Input: 2-FF synchronizer -> s_in (2-cycle latency). Rise/fall edges from s_in vs its previous value.
//  - run_cnt: clocks since last edge of s_in, saturates at all-ones; cleared on any edge.
//  - FSM: HUNT: wait for low run_cnt == GAP_SLOTS*CNTR_TICK-1 -> ARMED (no output).
//    ARMED: rise -> PULSE, pcnt=1.
//    PULSE: fall with run in [CNTR_TICK-TOL, CNTR_TICK+TOL] -> INTER; fall outside -> ERR;
//    high run > CNTR_TICK+TOL -> ERR (stuck-high).
//    INTER: rise with low run in [CNTR_TICK-TOL, CNTR_TICK+TOL] -> PULSE, pcnt+1; rise with low run
//    outside window but < GAP_SLOTS*CNTR_TICK -> ERR; low run reaches GAP_SLOTS*CNTR_TICK-1 -> CLOSE.
//    CLOSE (1 cycle): pcnt in 1..3 -> state<=pcnt-1, state_valid<=1, frame_done=1; pcnt>3 -> frame_err;
//    -> ARMED.
//    ERR (1 cycle): frame_err=1, state_valid<=0, state holds; -> HUNT.
//  - pcnt 3 bits, saturates at 7 (>3 already flags error at CLOSE).
//  - frame_done and frame_err never assert in the same cycle.
//  - err_cnt +1 per frame_err, saturates at 255, cleared only by reset.
//  - Loss: low run_cnt reaches LOSS_SLOTS*CNTR_TICK in ARMED -> state_valid<=0, no frame_err, stays ARMED.
//  - Latency: frame_done fires GAP_SLOTS*CNTR_TICK+2 clocks (+2 with deglitch) after last pulse falls
//    at led_in.
// CONFIGURATION
//  LED_DECODE_DEGLITCH_EN defined: 3-sample majority filter after the synchronizer (adds 2 clocks
//    latency); single-clock glitches are rejected.
//  Undefined: s_in = synchronizer output; a 1-clock glitch is a pulse and normally gives frame_err.
// STRUCTURE
//  led_status_pkg: FRAME_SLOTS=16, PULSE_SLOTS {10,12,14}, MAX_STATE=2, FSM state enum
//    (HUNT, ARMED, PULSE, INTER, CLOSE, ERR).
//  Sub-module led_in_sync: 2-FF sync + optional majority filter; output s_in.
//  Top: edge detect, run_cnt, FSM, output registers.
// TESTING (CNTR_TICK=4, TOL=1, GAP_SLOTS=8)
//  1. Reset, led_in low 64 clks, frame with pulse in slot 10 only -> frame_done, state=0, state_valid=1.
//  2. Repeating frames with pulses in 10,12,14 -> state=2 each frame; frame_done every 64 clks.
//  3. Pulse widths 3 and 5 clks -> accepted. Width 6 -> frame_err, state_valid=0, err_cnt=1,
//     state holds the previous value.
//  4. led_in stuck high after a rise -> frame_err at high run 6. Low 160+ clks -> state_valid drops,
//     no frame_err.
//  5. Four pulses at 1-slot spacing -> frame_err at CLOSE. Rst_n low mid-pulse -> all outputs 0 async,
//     FSM HUNT.
//  6. 1-clk glitch in slot 3: with LED_DECODE_DEGLITCH_EN -> next frame decodes normally;
//     without -> frame_err.

Source files
------------

// File: rtl/led_status_pkg.sv
// Shared definitions for the LED status blink code: frame geometry, the
// decoder FSM encoding and a saturating pulse-count helper.
package led_status_pkg;

    // Frame geometry of the blink line code
    localparam int FRAME_SLOTS    = 16;
    localparam int PULSE_SLOTS[3] = '{10, 12, 14};
    localparam int MAX_STATE      = 2;

    // Decoder FSM states
    typedef enum logic [2:0] {
        HUNT  = 3'd0,
        ARMED = 3'd1,
        PULSE = 3'd2,
        INTER = 3'd3,
        CLOSE = 3'd4,
        ERR   = 3'd5
    } fsm_state_t;

    // Pulse counter increment that sticks at 7; anything above 3 is already malformed
    function automatic logic [2:0] pcnt_inc(input logic [2:0] p);
        return (p == 3'd7) ? p : p + 3'd1;
    endfunction

endpackage

// File: rtl/led_in_sync.sv
// Brings the asynchronous LED input into the clock domain.
// Optional macro LED_DECODE_DEGLITCH_EN adds a 3-sample majority filter
// (two extra clocks of latency, single-clock glitches removed).
module led_in_sync (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_led,
    output logic o_s_in
);

    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_led;
            r_sync2 <= r_sync1;
        end
    end

`ifdef LED_DECODE_DEGLITCH_EN
    logic r_d1;
    logic r_d2;
    logic r_filt;

    // Majority of three consecutive samples; a lone sample can never win
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_d1   <= 1'b0;
            r_d2   <= 1'b0;
            r_filt <= 1'b0;
        end else begin
            r_d1   <= r_sync2;
            r_d2   <= r_d1;
            r_filt <= (r_sync2 & r_d1) | (r_sync2 & r_d2) | (r_d1 & r_d2);
        end
    end

    assign o_s_in = r_filt;
`else
    assign o_s_in = r_sync2;
`endif

endmodule

// File: rtl/led_blink_decoder.sv
// Receive side of the LED status blink code. Measures run lengths of the
// synchronized input and decodes 1/2/3 pulses into status 0/1/2.
// Optional macro LED_DECODE_DEGLITCH_EN enables the input majority filter.
module led_blink_decoder
    import led_status_pkg::*;
#(
    parameter int CNTR_TICK  = 4,
    parameter int TOL        = 1,
    parameter int GAP_SLOTS  = 8,
    parameter int LOSS_SLOTS = 40,
    parameter int RUN_W      = 8
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       led_in,
    output logic [1:0] state,
    output logic       state_valid,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic [2:0] o_dbg_fsm
);

    // Run lengths are compared one bit wider so the +1 never wraps
    localparam logic [RUN_W:0] WIN_LO   = (RUN_W+1)'(CNTR_TICK - TOL);
    localparam logic [RUN_W:0] WIN_HI   = (RUN_W+1)'(CNTR_TICK + TOL);
    localparam logic [RUN_W:0] GAP_RUN  = (RUN_W+1)'(GAP_SLOTS * CNTR_TICK - 1);
    localparam logic [RUN_W:0] LOSS_RUN = (RUN_W+1)'(LOSS_SLOTS * CNTR_TICK);

    logic             w_s_in;
    logic             r_s_prev;
    logic             w_rise;
    logic             w_fall;
    logic             w_low;
    logic             w_high;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W:0]   w_run;
    logic             w_in_win;

    fsm_state_t       r_fsm;
    fsm_state_t       w_fsm_nxt;
    logic [2:0]       r_pcnt;
    logic [2:0]       w_pcnt_nxt;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [7:0]       r_err_cnt;

    led_in_sync u_sync (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .i_led  (led_in),
        .o_s_in (w_s_in)
    );

    assign w_rise   = w_s_in & ~r_s_prev;
    assign w_fall   = ~w_s_in & r_s_prev;
    // Steady levels: on an edge cycle w_run still describes the run that just ended
    assign w_low    = ~w_s_in & ~r_s_prev;
    assign w_high   = w_s_in & r_s_prev;
    // Clocks since the last edge (r_run is cleared to 0 the clock after an edge)
    assign w_run    = {1'b0, r_run} + {{RUN_W{1'b0}}, 1'b1};
    assign w_in_win = (w_run >= WIN_LO) && (w_run <= WIN_HI);

    // Edge history and saturating run-length counter
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_s_prev <= 1'b0;
            r_run    <= '0;
        end else begin
            r_s_prev <= w_s_in;
            if (w_rise || w_fall) begin
                r_run <= '0;
            end else if (r_run != {RUN_W{1'b1}}) begin
                r_run <= r_run + {{(RUN_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next state plus next output values; strobes become visible in CLOSE/ERR
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_pcnt_nxt  = r_pcnt;
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_fsm)
            HUNT: begin
                if (w_low && (w_run == GAP_RUN)) begin
                    w_fsm_nxt = ARMED;
                end
            end
            ARMED: begin
                if (w_rise) begin
                    w_fsm_nxt  = PULSE;
                    w_pcnt_nxt = 3'd1;
                end else if (w_low && (w_run == LOSS_RUN)) begin
                    w_valid_nxt = 1'b0;
                end
            end
            PULSE: begin
                if (w_fall) begin
                    if (w_in_win) begin
                        w_fsm_nxt = INTER;
                    end else begin
                        w_fsm_nxt   = ERR;
                        w_err_nxt   = 1'b1;
                        w_valid_nxt = 1'b0;
                    end
                end else if (w_high && (w_run > WIN_HI)) begin
                    w_fsm_nxt   = ERR;
                    w_err_nxt   = 1'b1;
                    w_valid_nxt = 1'b0;
                end
            end
            INTER: begin
                if (w_rise) begin
                    if (w_in_win) begin
                        w_fsm_nxt  = PULSE;
                        w_pcnt_nxt = pcnt_inc(r_pcnt);
                    end else begin
                        w_fsm_nxt   = ERR;
                        w_err_nxt   = 1'b1;
                        w_valid_nxt = 1'b0;
                    end
                end else if (w_low && (w_run == GAP_RUN)) begin
                    w_fsm_nxt = CLOSE;
                    if ((r_pcnt != 3'd0) && (r_pcnt <= 3'(MAX_STATE + 1))) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = 2'(r_pcnt - 3'd1);
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            CLOSE:   w_fsm_nxt = ARMED;
            ERR:     w_fsm_nxt = HUNT;
            default: w_fsm_nxt = HUNT;
        endcase
    end

    // FSM, pulse counter and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_fsm     <= HUNT;
            r_pcnt    <= '0;
            r_state   <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign state       = r_state;
    assign state_valid = r_valid;
    assign frame_done  = r_done;
    assign frame_err   = r_err;
    assign err_cnt     = r_err_cnt;
    assign o_dbg_fsm   = r_fsm;

endmodule

// File: tb/tb_led_blink_decoder.sv
// Directed bench for led_blink_decoder (CNTR_TICK=4, TOL=1, GAP_SLOTS=8).
// Expectations follow the macro LED_DECODE_DEGLITCH_EN when it is defined.
module tb_led_blink_decoder;
  import led_status_pkg::*;

  localparam int TICK = 4;
`ifdef LED_DECODE_DEGLITCH_EN
  localparam int DG = 2;
`else
  localparam int DG = 0;
`endif
  localparam int PREFIX = PULSE_SLOTS[0] * TICK;
  localparam int FRAME  = FRAME_SLOTS * TICK;

  logic       Clk;
  logic       Rst_n;
  logic       led_in;
  logic [1:0] state;
  logic       state_valid;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic [2:0] o_dbg_fsm;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;
  int last_err_cyc = 0;
  int last_fall_cyc = 0;

  led_blink_decoder dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .led_in      (led_in),
    .state       (state),
    .state_valid (state_valid),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt),
    .o_dbg_fsm   (o_dbg_fsm)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  // strobe monitor, sampled on the falling edge
  always @(negedge Clk) begin
    if (frame_done === 1'b1) begin
      n_done++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
    if (frame_err === 1'b1) begin
      n_err++;
      last_err_cyc = cyc;
    end
    if (frame_done === 1'b1 && frame_err === 1'b1) n_both++;
  end

  // driver: hold led_in at v for n clocks, returning 1 time unit after a rising edge
  task automatic drive(input logic v, input int n);
    led_in = v;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // one frame: low prefix to slot 10, np pulses of width w separated by g, low padding to 64 clocks
  task automatic send_frame(input int np, input int w, input int g);
    int used;
    drive(1'b0, PREFIX);
    for (int i = 0; i < np; i++) begin
      drive(1'b1, w);
      if (i == np - 1) last_fall_cyc = cyc;
      else drive(1'b0, g);
    end
    used = PREFIX + np * w + (np - 1) * g;
    if (used < FRAME) drive(1'b0, FRAME - used);
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    led_in = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if ({state, state_valid, frame_done, frame_err, err_cnt} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {state, state_valid, frame_done, frame_err, err_cnt});
    end
    n_checks++;
    if (o_dbg_fsm !== HUNT) begin
      n_fail++;
      $display("FAIL reset_fsm: got %0d expected %0d", o_dbg_fsm, HUNT);
    end
    Rst_n = 1'b1;
  endtask

  task automatic test_single_pulse;
    int base_done;
    drive(1'b0, 64);
    n_checks++;
    if (o_dbg_fsm !== ARMED) begin
      n_fail++;
      $display("FAIL armed_after_gap: got %0d expected %0d", o_dbg_fsm, ARMED);
    end
    base_done = n_done;
    send_frame(1, 4, 4);
    drive(1'b0, 40);
    n_checks++;
    if (n_done !== base_done + 1) begin
      n_fail++;
      $display("FAIL single_done_count: got %0d expected %0d", n_done, base_done + 1);
    end
    n_checks++;
    if ({state, state_valid} !== 3'b001) begin
      n_fail++;
      $display("FAIL single_state: got state=%0d valid=%0d expected state=0 valid=1", state, state_valid);
    end
    n_checks++;
    if (last_done_cyc - last_fall_cyc !== 34 + DG) begin
      n_fail++;
      $display("FAIL single_latency: got %0d expected %0d", last_done_cyc - last_fall_cyc, 34 + DG);
    end
    n_checks++;
    if (n_err !== 0) begin
      n_fail++;
      $display("FAIL single_no_err: got %0d expected 0", n_err);
    end
  endtask

  task automatic test_repeat;
    int base_done;
    base_done = n_done;
    for (int f = 0; f < 3; f++) send_frame(3, 4, 4);
    drive(1'b0, 40);
    n_checks++;
    if (n_done !== base_done + 3) begin
      n_fail++;
      $display("FAIL repeat_done_count: got %0d expected %0d", n_done, base_done + 3);
    end
    n_checks++;
    if ({state, state_valid} !== 3'b101) begin
      n_fail++;
      $display("FAIL repeat_state: got state=%0d valid=%0d expected state=2 valid=1", state, state_valid);
    end
    n_checks++;
    if (last_done_cyc - prev_done_cyc !== 64) begin
      n_fail++;
      $display("FAIL repeat_period: got %0d expected 64", last_done_cyc - prev_done_cyc);
    end
    n_checks++;
    if (last_done_cyc - last_fall_cyc !== 34 + DG) begin
      n_fail++;
      $display("FAIL repeat_latency: got %0d expected %0d", last_done_cyc - last_fall_cyc, 34 + DG);
    end
  endtask

  task automatic test_width;
    int base_done;
    int base_err;
    base_done = n_done;
    send_frame(2, 3, 5);
    drive(1'b0, 40);
    n_checks++;
    if ({state, state_valid} !== 3'b011 || n_done !== base_done + 1) begin
      n_fail++;
      $display("FAIL width3: got state=%0d valid=%0d dones=%0d expected state=1 valid=1 dones=%0d",
               state, state_valid, n_done, base_done + 1);
    end
    send_frame(3, 5, 3);
    drive(1'b0, 40);
    n_checks++;
    if ({state, state_valid} !== 3'b101 || n_done !== base_done + 2) begin
      n_fail++;
      $display("FAIL width5: got state=%0d valid=%0d dones=%0d expected state=2 valid=1 dones=%0d",
               state, state_valid, n_done, base_done + 2);
    end
    base_err = n_err;
    send_frame(1, 6, 4);
    drive(1'b0, 40);
    n_checks++;
    if (n_err !== base_err + 1) begin
      n_fail++;
      $display("FAIL width6_err: got %0d expected %0d", n_err, base_err + 1);
    end
    n_checks++;
    if (err_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL width6_err_cnt: got %0d expected 1", err_cnt);
    end
    n_checks++;
    if ({state, state_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL width6_state: got state=%0d valid=%0d expected state=2 valid=0", state, state_valid);
    end
    n_checks++;
    if (n_done !== base_done + 2) begin
      n_fail++;
      $display("FAIL width6_no_done: got %0d expected %0d", n_done, base_done + 2);
    end
    n_checks++;
    if (o_dbg_fsm !== ARMED) begin
      n_fail++;
      $display("FAIL width6_rearm: got %0d expected %0d", o_dbg_fsm, ARMED);
    end
  endtask

  task automatic test_stuck_high;
    int base_err;
    int rise_cyc;
    send_frame(1, 4, 4);
    drive(1'b0, 40);
    n_checks++;
    if ({state, state_valid} !== 3'b001) begin
      n_fail++;
      $display("FAIL stuck_pre_state: got state=%0d valid=%0d expected state=0 valid=1", state, state_valid);
    end
    base_err = n_err;
    rise_cyc = cyc;
    drive(1'b1, 20);
    n_checks++;
    if (n_err !== base_err + 1) begin
      n_fail++;
      $display("FAIL stuck_err: got %0d expected %0d", n_err, base_err + 1);
    end
    n_checks++;
    if (last_err_cyc - rise_cyc !== 9 + DG) begin
      n_fail++;
      $display("FAIL stuck_err_time: got %0d expected %0d", last_err_cyc - rise_cyc, 9 + DG);
    end
    n_checks++;
    if (state_valid !== 1'b0 || err_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL stuck_outputs: got valid=%0d err_cnt=%0d expected valid=0 err_cnt=2", state_valid, err_cnt);
    end
    drive(1'b0, 200);
  endtask

  task automatic test_loss;
    int base_err;
    send_frame(1, 4, 4);
    drive(1'b0, 80);
    n_checks++;
    if ({state, state_valid} !== 3'b001) begin
      n_fail++;
      $display("FAIL loss_before: got state=%0d valid=%0d expected state=0 valid=1", state, state_valid);
    end
    base_err = n_err;
    drive(1'b0, 100);
    n_checks++;
    if (state_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_valid: got %0d expected 0", state_valid);
    end
    n_checks++;
    if (n_err !== base_err || err_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL loss_no_err: got errs=%0d err_cnt=%0d expected errs=%0d err_cnt=2", n_err, err_cnt, base_err);
    end
    n_checks++;
    if (o_dbg_fsm !== ARMED) begin
      n_fail++;
      $display("FAIL loss_fsm: got %0d expected %0d", o_dbg_fsm, ARMED);
    end
  endtask

  task automatic test_four_pulses;
    int base_done;
    int base_err;
    send_frame(2, 4, 4);
    drive(1'b0, 40);
    base_done = n_done;
    base_err = n_err;
    send_frame(4, 4, 4);
    drive(1'b0, 40);
    n_checks++;
    if (n_err !== base_err + 1 || n_done !== base_done) begin
      n_fail++;
      $display("FAIL four_err: got errs=%0d dones=%0d expected errs=%0d dones=%0d",
               n_err, n_done, base_err + 1, base_done);
    end
    n_checks++;
    if (err_cnt !== 8'd3 || state !== 2'd1) begin
      n_fail++;
      $display("FAIL four_outputs: got err_cnt=%0d state=%0d expected err_cnt=3 state=1", err_cnt, state);
    end
  endtask

  task automatic test_reset_mid;
    int base_done;
    drive(1'b0, 40);
    drive(1'b1, 3 + DG);
    n_checks++;
    if (o_dbg_fsm !== PULSE) begin
      n_fail++;
      $display("FAIL mid_in_pulse: got %0d expected %0d", o_dbg_fsm, PULSE);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    n_checks++;
    if ({state, state_valid, frame_done, frame_err, err_cnt} !== 13'd0 || o_dbg_fsm !== HUNT) begin
      n_fail++;
      $display("FAIL mid_reset: got outs=%h fsm=%0d expected outs=0 fsm=%0d",
               {state, state_valid, frame_done, frame_err, err_cnt}, o_dbg_fsm, HUNT);
    end
    led_in = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    drive(1'b0, 64);
    base_done = n_done;
    send_frame(1, 4, 4);
    drive(1'b0, 40);
    n_checks++;
    if ({state, state_valid} !== 3'b001 || n_done !== base_done + 1) begin
      n_fail++;
      $display("FAIL mid_recover: got state=%0d valid=%0d dones=%0d expected state=0 valid=1 dones=%0d",
               state, state_valid, n_done, base_done + 1);
    end
  endtask

  task automatic test_glitch;
    int base_done;
    int base_err;
    base_done = n_done;
    base_err = n_err;
    drive(1'b0, 3 * TICK);
    drive(1'b1, 1);
    drive(1'b0, PREFIX - 3 * TICK - 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4);
      if (i < 2) drive(1'b0, 4);
    end
    drive(1'b0, FRAME - PREFIX - 20);
    send_frame(3, 4, 4);
    drive(1'b0, 40);
    n_checks++;
    if (n_done !== base_done + (DG != 0 ? 2 : 1)) begin
      n_fail++;
      $display("FAIL glitch_dones: got %0d expected %0d", n_done, base_done + (DG != 0 ? 2 : 1));
    end
    n_checks++;
    if (n_err !== base_err + (DG != 0 ? 0 : 1) || err_cnt !== 8'((DG != 0) ? 0 : 1)) begin
      n_fail++;
      $display("FAIL glitch_errs: got errs=%0d err_cnt=%0d expected errs=%0d err_cnt=%0d",
               n_err, err_cnt, base_err + (DG != 0 ? 0 : 1), (DG != 0) ? 0 : 1);
    end
    n_checks++;
    if ({state, state_valid} !== 3'b101) begin
      n_fail++;
      $display("FAIL glitch_state: got state=%0d valid=%0d expected state=2 valid=1", state, state_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_repeat();
    test_width();
    test_stuck_high();
    test_loss();
    test_four_pulses();
    test_reset_mid();
    test_glitch();
    n_checks++;
    if (n_both !== 0) begin
      n_fail++;
      $display("FAIL done_err_exclusive: got %0d overlaps expected 0", n_both);
    end
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
